alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Iterative unsigned multiply/divide sequencer for the EXE stage of the 5-stage MIPS pipeline.
- Owns one internal ALU instance and drives it with `EXE_ADD`/`EXE_SUB` once per cycle to run shift-add MULTU and restoring DIVU over 32 iterations.
- Holds the architectural HI/LO registers.
- Raises busy so the hazard unit stalls IF/ID/EXE until the result is committed.

Parameters:
- WORD_LEN, 32, operand/result width (from defines.v `WORD_LEN`).
- ITER, 32, iteration count; must equal WORD_LEN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  1  0 = MULTU, 1 = DIVU
- src_a  in  WORD_LEN  multiplicand / dividend
- src_b  in  WORD_LEN  multiplier / divisor
- flush  in  1  pipeline flush; aborts any in-flight operation
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wr_data  in  WORD_LEN  MTHI/MTLO data
- busy  out  1  high in CALC and DONE; drives the pipeline stall
- done  out  1  one-cycle pulse, asserted in the DONE state
- hi  out  WORD_LEN  architectural HI
- lo  out  WORD_LEN  architectural LO

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE; hi, lo and all working registers clear to 0.
  - busy and done are 0.
  - Reset mid-operation discards the operation; no partial result reaches hi/lo.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on start & ~flush. Latch src_a, src_b and op into working registers; cnt := 0.
  - IDLE -> DONE instead when op = DIVU and src_b = 0 (divide by zero).
  - CALC -> DONE when cnt = ITER-1 at the end of that cycle's iteration.
  - DONE -> IDLE unconditionally.
  - flush in CALC or DONE -> IDLE. hi/lo keep their pre-operation values; no done pulse. In DONE, flush suppresses the commit.
- Latency: start in cycle 0.
  - busy is high in cycles 1..33.
  - done pulses in cycle 33.
  - New hi/lo are visible in cycle 33.
  - Earliest next accepted start is cycle 34.
  - Divide-by-zero: done in cycle 1, busy only in cycle 1.
- start while busy: ignored, with no queueing; the issuing stage is responsible for stalling.
- MULTU datapath. Working regs: acc[31:0], q[31:0] = multiplier, mcand.
  - Each CALC cycle: ALU computes acc + (q[0] ? mcand : 0) with `EXE_ADD`.
  - carry = (sum < acc) when q[0] = 1, else 0.
  - Update {acc, q} := {carry, sum, q} >> 1, dropping the shifted-out bit.
  - On entering DONE: hi := acc, lo := q.
- DIVU datapath. Working regs: rem[31:0], q[31:0] = dividend, dvsr.
  - Each cycle: shifted = {rem, q[31]} (33 bits); ALU computes shifted[31:0] - dvsr with `EXE_SUB`.
  - If shifted >= {0, dvsr}: rem := ALU result and new q bit = 1.
  - Else: rem := shifted[31:0] and new q bit = 0.
  - Then q := {q[30:0], qbit}.
  - On DONE: hi := rem (remainder), lo := q (quotient).
  - Divide by zero: hi := src_a, lo := 32'hFFFF_FFFF.
- MTHI/MTLO:
  - Honoured only in IDLE with no start in the same cycle; otherwise ignored.
  - wr_hi and wr_lo may both be set; both registers take wr_data.
  - start together with wr_hi/wr_lo in IDLE: start wins and the write is dropped.
- ALU commands other than `EXE_ADD`/`EXE_SUB` are never issued. The ALU input value is don't-care while IDLE.
- hi/lo change only on reset, in DONE, or on an accepted MTHI/MTLO write.

Decomposition:
- defines.v gains:
  - `MD_OP_MULTU` = 1'b0, `MD_OP_DIVU` = 1'b1.
  - State encodings `MD_IDLE` = 2'd0, `MD_CALC` = 2'd1, `MD_DONE` = 2'd2.
  - `MD_ITER` = 32.
- Existing `WORD_LEN`, `EXE_CMD_LEN`, `EXE_ADD` and `EXE_SUB` are reused.
- Sub-module: one instance of the existing ALU, with val1 = acc/rem-path operand, val2 = mcand/dvsr (gated), EXE_CMD from the FSM.
- No other sub-modules; FSM and shift registers stay inline.

Test Plan:
- Reset, then MULTU src_a = 6, src_b = 7 -> busy cycles 1..33, done pulse in cycle 33, hi = 0, lo = 42.
- MULTU src_a = 32'hFFFF_FFFF, src_b = 32'hFFFF_FFFF -> hi = 32'hFFFF_FFFE, lo = 32'h0000_0001 (carry path exercised).
- DIVU src_a = 100, src_b = 7 -> cycle 33: lo = 14, hi = 2.
- DIVU src_a = 32'h1234_5678, src_b = 0 -> done in cycle 1, lo = 32'hFFFF_FFFF, hi = 32'h1234_5678, busy low by cycle 2.
- Preload hi/lo via wr_hi/wr_lo = 32'hA5A5_A5A5. Start MULTU 3*5, assert flush in cycle 10 -> no done, hi/lo still 32'hA5A5_A5A5. Second start in cycle 5 of a new operation is ignored: result matches the first operands only.
- Start DIVU 100/7, drop rst low in cycle 20 -> immediately state IDLE, busy = 0, hi = lo = 0. Operation after release yields correct results.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// alu_muldiv_seq_pkg: shared widths, ALU command codes, mul/div op codes and FSM state type
package alu_muldiv_seq_pkg;
    localparam int WORD_LEN    = 32;
    localparam int EXE_CMD_LEN = 4;
    localparam int MD_ITER     = 32;

    localparam logic [EXE_CMD_LEN-1:0] EXE_ADD = 4'b0000;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SUB = 4'b0010;
    localparam logic [EXE_CMD_LEN-1:0] EXE_AND = 4'b0100;
    localparam logic [EXE_CMD_LEN-1:0] EXE_OR  = 4'b0101;
    localparam logic [EXE_CMD_LEN-1:0] EXE_NOR = 4'b0110;
    localparam logic [EXE_CMD_LEN-1:0] EXE_XOR = 4'b0111;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SLL = 4'b1000;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SRA = 4'b1001;
    localparam logic [EXE_CMD_LEN-1:0] EXE_SRL = 4'b1010;

    localparam logic MD_OP_MULTU = 1'b0;
    localparam logic MD_OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;
endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// alu_muldiv_seq_alu: EXE-stage combinational ALU
//   val1, val2 : operands
//   exe_cmd    : operation select (EXE_* codes)
//   alu_res    : result
module alu_muldiv_seq_alu
    import alu_muldiv_seq_pkg::*;
(
    input  logic [WORD_LEN-1:0]    val1,
    input  logic [WORD_LEN-1:0]    val2,
    input  logic [EXE_CMD_LEN-1:0] exe_cmd,
    output logic [WORD_LEN-1:0]    alu_res
);
    logic [$clog2(WORD_LEN)-1:0] sh;

    assign sh = val2[$clog2(WORD_LEN)-1:0];

    always_comb begin
        alu_res = '0;
        case (exe_cmd)
            EXE_ADD: alu_res = val1 + val2;
            EXE_SUB: alu_res = val1 - val2;
            EXE_AND: alu_res = val1 & val2;
            EXE_OR:  alu_res = val1 | val2;
            EXE_NOR: alu_res = ~(val1 | val2);
            EXE_XOR: alu_res = val1 ^ val2;
            EXE_SLL: alu_res = val1 << sh;
            EXE_SRA: alu_res = $signed(val1) >>> sh;
            EXE_SRL: alu_res = val1 >> sh;
            default: alu_res = '0;
        endcase
    end
endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative MULTU/DIVU sequencer owning the HI/LO registers
//   clk, rst (async, active-low)
//   start, op (0 MULTU / 1 DIVU), src_a, src_b : operation request, sampled in IDLE
//   flush                                      : aborts an in-flight operation
//   wr_hi, wr_lo, wr_data                      : MTHI/MTLO writes, honoured in IDLE only
//   busy, done                                 : stall request / completion pulse
//   hi, lo                                     : architectural HI/LO
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int WORD_LEN = 32,
    parameter int ITER     = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op,
    input  logic [WORD_LEN-1:0] src_a,
    input  logic [WORD_LEN-1:0] src_b,
    input  logic                flush,
    input  logic                wr_hi,
    input  logic                wr_lo,
    input  logic [WORD_LEN-1:0] wr_data,
    output logic                busy,
    output logic                done,
    output logic [WORD_LEN-1:0] hi,
    output logic [WORD_LEN-1:0] lo
);
    localparam int CNT_W = $clog2(ITER);

    md_state_t                 state;
    logic [WORD_LEN-1:0]       acc, q, b, hi_q, lo_q;
    logic [WORD_LEN-1:0]       val1, val2, alu_res, shifted_lo;
    logic [EXE_CMD_LEN-1:0]    exe_cmd;
    logic [CNT_W-1:0]          cnt;
    logic                      op_q, carry, ge, commit;

    // Divide: low 32 bits of {rem, q[msb]}; bit 32 of that value is acc[msb].
    assign shifted_lo = {acc[WORD_LEN-2:0], q[WORD_LEN-1]};
    assign val1       = op_q ? shifted_lo : acc;
    assign val2       = (op_q | q[0]) ? b : '0;
    assign exe_cmd    = op_q ? EXE_SUB : EXE_ADD;
    assign carry      = q[0] & (alu_res < acc);
    assign ge         = acc[WORD_LEN-1] | (shifted_lo >= b);

    alu_muldiv_seq_alu u_alu (
        .val1    (val1),
        .val2    (val2),
        .exe_cmd (exe_cmd),
        .alu_res (alu_res)
    );

    // The working registers already hold the final result in DONE, so the
    // result is forwarded there and only written into HI/LO when DONE retires
    // unflushed; a flush in DONE therefore leaves the old values visible.
    assign commit = (state == MD_DONE) & ~flush;
    assign busy   = state != MD_IDLE;
    assign done   = commit;
    assign hi     = commit ? acc : hi_q;
    assign lo     = commit ? q : lo_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MD_IDLE;
            acc   <= '0;
            q     <= '0;
            b     <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            cnt   <= '0;
            op_q  <= MD_OP_MULTU;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (start && !flush) begin
                        op_q <= op;
                        cnt  <= '0;
                        b    <= (op == MD_OP_DIVU) ? src_b : src_a;
                        if (op == MD_OP_DIVU && src_b == '0) begin
                            acc   <= src_a;
                            q     <= '1;
                            state <= MD_DONE;
                        end else begin
                            acc   <= '0;
                            q     <= (op == MD_OP_DIVU) ? src_a : src_b;
                            state <= MD_CALC;
                        end
                    end else if (!start) begin
                        if (wr_hi) hi_q <= wr_data;
                        if (wr_lo) lo_q <= wr_data;
                    end
                end
                MD_CALC: begin
                    if (flush) begin
                        state <= MD_IDLE;
                    end else begin
                        if (op_q == MD_OP_DIVU) begin
                            acc <= ge ? alu_res : shifted_lo;
                            q   <= {q[WORD_LEN-2:0], ge};
                        end else begin
                            acc <= {carry, alu_res[WORD_LEN-1:1]};
                            q   <= {alu_res[0], q[WORD_LEN-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(ITER - 1)) state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (!flush) begin
                        hi_q <= acc;
                        lo_q <= q;
                    end
                    state <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed self-checking bench for alu_muldiv_seq
module tb_alu_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          total = 0;
    int          bad = 0;

    alu_muldiv_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .flush   (flush),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one operation in cycle 0 and checks every cycle up to lat+1.
    // fc: cycle in which flush is raised (0 = none); ic: cycle in which a
    // stray DIVU 100/7 start is presented (0 = none); wr: MTHI/MTLO strobed with start.
    task automatic run(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic [31:0] ph, input logic [31:0] pl,
                       input int lat, input int fc, input int ic, input logic wr);
        logic fl, be, de, fin;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        wr_hi = wr; wr_lo = wr; wr_data = 32'hDEAD_BEEF;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; flush = 1'b0;
            if (c == ic) begin start = 1'b1; op = 1'b1; src_a = 32'd100; src_b = 32'd7; end
            if (c == fc) flush = 1'b1;
            #1;
            fl  = (fc != 0) && (c > fc);
            be  = !fl && (c <= lat);
            de  = (c == lat) && (fc == 0);
            fin = (c >= lat) && (fc == 0);
            chk($sformatf("%s busy c%0d", tag, c), {31'b0, busy}, {31'b0, be});
            chk($sformatf("%s done c%0d", tag, c), {31'b0, done}, {31'b0, de});
            chk($sformatf("%s hi c%0d", tag, c), hi, fin ? eh : ph);
            chk($sformatf("%s lo c%0d", tag, c), lo, fin ? el : pl);
            if (fl) break;
        end
        start = 1'b0; flush = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst hi", hi, 32'd0);
        chk("rst lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run("mul6x7", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 32'd0, 32'd0, 33, 0, 0, 1'b0);
        run("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
            32'd0, 32'd42, 33, 0, 0, 1'b0);
        run("div100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14,
            32'hFFFF_FFFE, 32'h0000_0001, 33, 0, 0, 1'b0);
        run("div0", 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF,
            32'd2, 32'd14, 1, 0, 0, 1'b0);

        @(negedge clk);
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        #1;
        chk("mthi", hi, 32'hA5A5_A5A5);
        chk("mtlo", lo, 32'hA5A5_A5A5);

        run("flushcalc", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15,
            32'hA5A5_A5A5, 32'hA5A5_A5A5, 33, 10, 0, 1'b0);
        run("ignstart", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15,
            32'hA5A5_A5A5, 32'hA5A5_A5A5, 33, 0, 5, 1'b0);
        run("startwr", 1'b0, 32'd2, 32'd2, 32'd0, 32'd4, 32'd0, 32'd15, 33, 0, 0, 1'b1);
        run("flushdone", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 32'd0, 32'd4, 33, 33, 0, 1'b0);

        @(negedge clk);
        start = 1'b1; op = 1'b1; src_a = 32'd100; src_b = 32'd7;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        chk("midrst busy", {31'b0, busy}, 32'd0);
        chk("midrst done", {31'b0, done}, 32'd0);
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run("postrst", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 32'd0, 32'd0, 33, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
